// File: rtl/ahb_decoder_if.sv
// ahb_decoder_if: bus-side signals of the AHB address decoder.
// The master modport is the driving side (address phase + bus ready);
// the slave modport is the decoder itself.
interface ahb_decoder_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel_1;
    logic        hsel_2;
    logic        hsel_3;
    logic        hsel_4;
    logic [1:0]  sel;
    logic        dflt_active;
    logic        dflt_hreadyout;
    logic        dflt_hresp;

    modport master (
        output haddr, htrans, hready,
        input  hsel_1, hsel_2, hsel_3, hsel_4, sel,
        input  dflt_active, dflt_hreadyout, dflt_hresp
    );

    modport slave (
        input  haddr, htrans, hready,
        output hsel_1, hsel_2, hsel_3, hsel_4, sel,
        output dflt_active, dflt_hreadyout, dflt_hresp
    );
endinterface

// File: rtl/ahb_decoder.sv
// ahb_decoder: decodes haddr[31:28] into four slave selects, registers the
// data-phase mux select and, when DEFAULT_SLAVE_EN is defined, provides a
// default slave that returns a two-cycle ERROR for unmapped active transfers.
// Without DEFAULT_SLAVE_EN, unmapped addresses alias to slave 4.
module ahb_decoder (
    input logic          hclk,
    input logic          hreset,
    ahb_decoder_if.slave bus
);
    logic [3:0] hsel_vec;
    logic       mapped;
    logic [1:0] slave_idx;
    logic [1:0] sel_q;

    // Combinational address-phase decode of the top address nibble
    always_comb begin
        hsel_vec  = 4'b0000;
        mapped    = 1'b1;
        slave_idx = 2'b11;
        unique case (bus.haddr[31:28])
            4'h0: begin
                hsel_vec  = 4'b0001;
                slave_idx = 2'b00;
            end
            4'h1: begin
                hsel_vec  = 4'b0010;
                slave_idx = 2'b01;
            end
            4'h2: begin
                hsel_vec  = 4'b0100;
                slave_idx = 2'b10;
            end
            4'h3: begin
                hsel_vec  = 4'b1000;
                slave_idx = 2'b11;
            end
            default: begin
`ifdef DEFAULT_SLAVE_EN
                mapped    = 1'b0;
`else
                hsel_vec  = 4'b1000;
`endif
            end
        endcase
    end

    assign bus.hsel_1 = hsel_vec[0];
    assign bus.hsel_2 = hsel_vec[1];
    assign bus.hsel_3 = hsel_vec[2];
    assign bus.hsel_4 = hsel_vec[3];

    // Data-phase select: loads on accepted address phase, 2'b11 when unmapped
    always_ff @(posedge hclk) begin
        if (hreset) begin
            sel_q <= 2'b00;
        end else if (bus.hready) begin
            sel_q <= mapped ? slave_idx : 2'b11;
        end
    end

    assign bus.sel = sel_q;

`ifdef DEFAULT_SLAVE_EN
    typedef enum logic [1:0] {StIdle, StErr1, StErr2} dflt_state_e;

    dflt_state_e state_q;
    logic        active_q;
    logic        hreadyout_q;
    logic        hresp_q;
    logic        err_req;

    // Only an accepted NONSEQ/SEQ to an unmapped address earns an ERROR
    assign err_req = bus.hready & ~mapped & bus.htrans[1];

    // Data phase ownership follows the last accepted address phase
    always_ff @(posedge hclk) begin
        if (hreset) begin
            active_q <= 1'b0;
        end else if (bus.hready) begin
            active_q <= ~mapped;
        end
    end

    // Default-slave FSM with registered ready/response
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StErr2: begin
                    if (err_req) begin
                        state_q     <= StErr1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= StIdle;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                StErr1: begin
                    state_q     <= StErr2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dflt_active    = active_q;
    assign bus.dflt_hreadyout = hreadyout_q;
    assign bus.dflt_hresp     = hresp_q;
`else
    assign bus.dflt_active    = 1'b0;
    assign bus.dflt_hreadyout = 1'b1;
    assign bus.dflt_hresp     = 1'b0;
`endif

    // Low address bits (and htrans when the default slave is absent) are not decoded
    logic unused_sigs;
    assign unused_sigs = ^{bus.haddr[27:0], bus.htrans};

endmodule

// File: tb/tb_ahb_decoder.sv
// tb_ahb_decoder: randomized and directed checks of ahb_decoder against a
// queue-based model of the default-slave response beats.
module tb_ahb_decoder;
    logic hclk;
    logic hreset;

    ahb_decoder_if bus ();

    ahb_decoder dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [1:0] m_sel;
    logic       m_act;
    logic [1:0] rsp_q[$];   // pending default-slave beats as {hreadyout, hresp}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_hsel(input logic [31:0] a);
        int n;
        n = int'(a[31:28]);
        if (n < 4) return 4'(1 << n);
`ifdef DEFAULT_SLAVE_EN
        return 4'b0000;
`else
        return 4'b1000;
`endif
    endfunction

    function automatic bit model_mapped(input logic [31:0] a);
`ifdef DEFAULT_SLAVE_EN
        return a[31:28] < 4'h4;
`else
        return 1'b1;
`endif
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, check outputs
    task automatic step(input logic rst, input logic [31:0] a, input logic [1:0] tr,
                        input logic rdy);
        logic [1:0] beat;
        @(negedge hclk);
        hreset     = rst;
        bus.haddr  = a;
        bus.htrans = tr;
        bus.hready = rdy;
        #1;
        check("hsel", 32'({bus.hsel_4, bus.hsel_3, bus.hsel_2, bus.hsel_1}),
              32'(model_hsel(a)));
        @(posedge hclk);
        if (rst) begin
            m_sel = 2'b00;
            m_act = 1'b0;
            rsp_q.delete();
        end else begin
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
`ifdef DEFAULT_SLAVE_EN
            if (rsp_q.size() == 0 && rdy && !model_mapped(a) && tr[1]) begin
                rsp_q.push_back(2'b01);
                rsp_q.push_back(2'b11);
            end
`endif
            if (rdy) begin
                m_sel = (model_mapped(a) && a[31:28] < 4'h4) ? a[29:28] : 2'b11;
                m_act = !model_mapped(a);
            end
        end
        #1;
        beat = (rsp_q.size() == 0) ? 2'b10 : rsp_q[0];
        check("sel", 32'(bus.sel), 32'(m_sel));
        check("dflt_active", 32'(bus.dflt_active), 32'(m_act));
        check("dflt_hreadyout", 32'(bus.dflt_hreadyout), 32'(beat[1]));
        check("dflt_hresp", 32'(bus.dflt_hresp), 32'(beat[0]));
    endtask

    initial begin
        logic [31:0] a;
        hreset     = 1'b1;
        bus.haddr  = '0;
        bus.htrans = 2'b00;
        bus.hready = 1'b1;
        m_sel      = 2'b00;
        m_act      = 1'b0;

        // Reset values
        step(1'b1, 32'h0, 2'b00, 1'b1);
        step(1'b1, 32'h2000_0000, 2'b10, 1'b1);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_active", 32'(bus.dflt_active), 32'h0);
        check("rst_hreadyout", 32'(bus.dflt_hreadyout), 32'h1);
        check("rst_hresp", 32'(bus.dflt_hresp), 32'h0);
        check("rst_hsel_3", 32'(bus.hsel_3), 32'h1);

        // Slave 2 select and one-cycle sel latency
        step(1'b0, 32'h1000_0004, 2'b10, 1'b1);
        check("s2_hsel_2", 32'(bus.hsel_2), 32'h1);
        check("s2_sel", 32'(bus.sel), 32'h1);

        // sel holds during wait states
        step(1'b0, 32'h3000_0000, 2'b10, 1'b1);
        check("s4_sel", 32'(bus.sel), 32'h3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0000_0000, 2'b10, 1'b0);
            check("hold_sel", 32'(bus.sel), 32'h3);
        end

`ifdef DEFAULT_SLAVE_EN
        // Two-cycle ERROR response
        step(1'b0, 32'h8000_0000, 2'b10, 1'b1);
        check("err_active", 32'(bus.dflt_active), 32'h1);
        check("err1_rdy", 32'(bus.dflt_hreadyout), 32'h0);
        check("err1_resp", 32'(bus.dflt_hresp), 32'h1);
        check("err_sel", 32'(bus.sel), 32'h3);
        step(1'b0, 32'h0, 2'b00, 1'b0);
        check("err2_rdy", 32'(bus.dflt_hreadyout), 32'h1);
        check("err2_resp", 32'(bus.dflt_hresp), 32'h1);
        step(1'b0, 32'h0, 2'b00, 1'b1);
        check("idle_rdy", 32'(bus.dflt_hreadyout), 32'h1);
        check("idle_resp", 32'(bus.dflt_hresp), 32'h0);
        check("idle_active", 32'(bus.dflt_active), 32'h0);

        // Back-to-back error: ERR2 -> ERR1 without IDLE
        step(1'b0, 32'hC000_0010, 2'b10, 1'b1);
        step(1'b0, 32'h0, 2'b00, 1'b0);
        step(1'b0, 32'h9000_0000, 2'b11, 1'b1);
        check("b2b_rdy", 32'(bus.dflt_hreadyout), 32'h0);
        check("b2b_resp", 32'(bus.dflt_hresp), 32'h1);
        step(1'b0, 32'h0, 2'b00, 1'b0);
        check("b2b_err2_resp", 32'(bus.dflt_hresp), 32'h1);
        step(1'b0, 32'h0, 2'b00, 1'b1);

        // Unmapped IDLE: owned by default slave, zero-wait OKAY
        step(1'b0, 32'hA000_0000, 2'b00, 1'b1);
        check("uidle_active", 32'(bus.dflt_active), 32'h1);
        check("uidle_rdy", 32'(bus.dflt_hreadyout), 32'h1);
        check("uidle_resp", 32'(bus.dflt_hresp), 32'h0);

        // Reset aborts an error response
        step(1'b0, 32'h8000_0000, 2'b10, 1'b1);
        step(1'b1, 32'h8000_0000, 2'b10, 1'b1);
        check("abort_rdy", 32'(bus.dflt_hreadyout), 32'h1);
        check("abort_resp", 32'(bus.dflt_hresp), 32'h0);
        check("abort_active", 32'(bus.dflt_active), 32'h0);
        check("abort_sel", 32'(bus.sel), 32'h0);
`else
        // Unmapped aliases to slave 4
        step(1'b0, 32'hF000_0000, 2'b10, 1'b1);
        check("alias_hsel_4", 32'(bus.hsel_4), 32'h1);
        check("alias_sel", 32'(bus.sel), 32'h3);
        check("alias_resp", 32'(bus.dflt_hresp), 32'h0);
        check("alias_active", 32'(bus.dflt_active), 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            a[31:28] = 4'($urandom_range(0, 7) < 4 ? $urandom_range(0, 3) : $urandom_range(4, 15));
            step(($urandom_range(0, 49) == 0), a, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_decoder.md
AHB_DECODER -- requirements
Module: ahb_decoder

Interface
REQ-001: The block SHALL have the port hclk, input, 1 bit: the single bus clock; all state updates on the rising edge.
REQ-002: The block SHALL have the port hreset, input, 1 bit: reset, synchronous and active-high.
REQ-003: The block SHALL have the port haddr, input, 32 bits: address-phase address from the master.
REQ-004: The block SHALL have the port htrans, input, 2 bits: transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-005: The block SHALL have the port hready, input, 1 bit: bus-level ready (response-mux output); 1 = address phase accepted this cycle.
REQ-006: The block SHALL have the ports hsel_1 .. hsel_4, output, 1 bit each: combinational address-phase slave selects.
REQ-007: The block SHALL have the port sel, output, 2 bits: registered data-phase select driving the slave response multiplexor.
REQ-008: The block SHALL have the port dflt_active, output, 1 bit: data phase owned by the default slave; the top level then uses the dflt_* signals in place of the multiplexor outputs.
REQ-009: The block SHALL have the port dflt_hreadyout, output, 1 bit: default-slave ready.
REQ-010: The block SHALL have the port dflt_hresp, output, 1 bit: default-slave response (0 OKAY, 1 ERROR).

Function
REQ-011: Decode SHALL use haddr[31:28]: 0x0 -> slave 1, 0x1 -> slave 2, 0x2 -> slave 3, 0x3 -> slave 4; any other value is unmapped.
REQ-012: hsel_N SHALL be a pure combinational decode of haddr, independent of htrans and hready; at most one hsel_N SHALL be high.
REQ-013: On each rising hclk with hready=1, sel SHALL load the decoded index (slave N -> N-1); with hready=0, sel SHALL hold.
REQ-014: The latency from address phase to sel SHALL be exactly one accepted cycle; sel SHALL never change while hready=0.
REQ-015: Default-slave FSM states SHALL be IDLE, ERR1, ERR2.
REQ-016: IDLE -> ERR1 SHALL occur when, at a rising edge, hready=1, the address is unmapped and htrans[1]=1 (NONSEQ/SEQ); otherwise the FSM SHALL remain in IDLE.
REQ-017: ERR1 -> ERR2 SHALL be unconditional.
REQ-018: From ERR2, the FSM SHALL go to ERR1 if the REQ-016 condition holds at that edge, else to IDLE.
REQ-019: Outputs by state SHALL be: IDLE: dflt_hreadyout=1, dflt_hresp=0; ERR1: dflt_hreadyout=0, dflt_hresp=1; ERR2: dflt_hreadyout=1, dflt_hresp=1.
REQ-020: dflt_active SHALL be registered: load 1 when hready=1 and the address is unmapped, load 0 when hready=1 and the address is mapped, and hold when hready=0.
REQ-021: An unmapped IDLE/BUSY transfer SHALL produce dflt_active=1 with a zero-wait OKAY (FSM stays IDLE).
REQ-022: When dflt_active=1, sel SHALL be 2'b11 (don't-care to the multiplexor; fixed for determinism).

Reset
REQ-023: While hreset=1 at a rising edge: sel=2'b00, dflt_active=0, FSM=IDLE, dflt_hreadyout=1, dflt_hresp=0.
REQ-024: Reset asserted in ERR1 or ERR2 SHALL abort the error response; the next cycle SHALL show the REQ-023 values.
REQ-025: hsel_N SHALL follow haddr combinationally during reset.

Configuration
REQ-026: Macro DEFAULT_SLAVE_EN defined: REQ-011..REQ-024 SHALL apply as written.
REQ-027: Macro DEFAULT_SLAVE_EN undefined: unmapped addresses SHALL alias to slave 4 (hsel_4=1, sel=2'b11); the FSM SHALL be absent; dflt_active=0, dflt_hreadyout=1 and dflt_hresp=0 SHALL be held constant.

Verification
REQ-028: The bench SHALL cover: haddr 0x1000_0004, NONSEQ, hready=1 -> hsel_2=1 immediately; sel=2'b01 after the next edge.
REQ-029: The bench SHALL cover: haddr 0x3000_0000 accepted, then hready=0 for 3 cycles with haddr 0x0000_0000 -> sel holds 2'b11 for all 3 cycles.
REQ-030: The bench SHALL cover (DEFAULT_SLAVE_EN): haddr 0x8000_0000 NONSEQ accepted -> dflt_active=1; cycle 1: hreadyout=0, hresp=1; cycle 2: hreadyout=1, hresp=1; then IDLE.
REQ-031: The bench SHALL cover (DEFAULT_SLAVE_EN): unmapped NONSEQ issued in the ERR2 cycle -> ERR2->ERR1 with no IDLE gap.
REQ-032: The bench SHALL cover (DEFAULT_SLAVE_EN): hreset=1 during ERR1 -> next cycle dflt_hreadyout=1, dflt_hresp=0, dflt_active=0, sel=2'b00.
REQ-033: The bench SHALL cover (macro undefined): haddr 0xF000_0000 NONSEQ -> hsel_4=1, sel=2'b11, dflt_hresp stays 0.
